// File: rtl/spi_slave_ctrl.sv
// spi_slave_ctrl: SPI slave front end for the single-port RAM.
// Deserialises one {cmd[1:0], payload} word per ss_n frame onto rx_data/rx_valid
// and, for read-data words, serialises the RAM's tx_data back on miso.
// Optional build macro SPI_CMD_CHK_EN adds the cmd_err output: a completed word
// whose command bits disagree with the path it arrived on is dropped and flagged.
module spi_slave_ctrl #(
    parameter int DATA_W     = 8,
    parameter int TX_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ss_n,
    input  logic              mosi,
    output logic              miso,
    output logic [DATA_W+1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid
`ifdef SPI_CMD_CHK_EN
    ,
    output logic              cmd_err
`endif
);

    localparam int CNT_W = $clog2(DATA_W + 3);
    localparam int TO_W  = $clog2(TX_TIMEOUT + 1);
    localparam int TXC_W = $clog2(DATA_W);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W + 2);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TX_TIMEOUT - 1);
    localparam logic [TXC_W-1:0] TX_FIRST = TXC_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHK_CMD,
        S_WRITE,
        S_READ_ADD,
        S_READ_DATA
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    logic [CNT_W-1:0]    r_bit_cnt;
    logic [DATA_W+1:0]   r_rx_shift;
    logic                r_word_done;
    logic                r_rd_addr_seen;
    logic                r_rd_active;
    logic                r_wait_tx;
    logic [TO_W-1:0]     r_to_cnt;
    logic                r_tx_busy;
    logic [DATA_W-1:0]   r_tx_shift;
    logic [TXC_W-1:0]    r_tx_cnt;
    logic                r_miso;
    logic [DATA_W+1:0]   r_rx_data;
    logic                r_rx_valid;

    logic                w_sample;
    logic                w_emit;
    logic                w_abort;
    logic                w_cmd_ok;

`ifdef SPI_CMD_CHK_EN
    logic                r_cmd_err;
    assign cmd_err = r_cmd_err;
`endif

    assign miso     = r_miso;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode plus the per-edge sample / emit / abort strobes.
    always_comb begin
        w_next_state = r_state;
        w_sample     = 1'b0;
        w_emit       = 1'b0;
        w_abort      = 1'b0;
        w_cmd_ok     = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (!ss_n) begin
                    w_next_state = S_CHK_CMD;
                end
            end
            S_CHK_CMD: begin
                if (ss_n) begin
                    w_next_state = S_IDLE;
                    w_abort      = 1'b1;
                end else begin
                    w_sample = 1'b1;
                    if (!mosi) begin
                        w_next_state = S_WRITE;
                    end else if (r_rd_addr_seen) begin
                        w_next_state = S_READ_DATA;
                    end else begin
                        w_next_state = S_READ_ADD;
                    end
                end
            end
            S_WRITE, S_READ_ADD, S_READ_DATA: begin
                if (ss_n) begin
                    w_next_state = S_IDLE;
                    w_abort      = 1'b1;
                end else if (r_bit_cnt != LAST_CNT) begin
                    w_sample = 1'b1;
                end else if (!r_word_done) begin
                    // All bits in: forward the word once; later bits are ignored.
                    w_emit = 1'b1;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
`ifdef SPI_CMD_CHK_EN
        case (r_state)
            S_READ_ADD:  w_cmd_ok = (r_rx_shift[DATA_W+1:DATA_W] == 2'b10);
            S_READ_DATA: w_cmd_ok = (r_rx_shift[DATA_W+1:DATA_W] == 2'b11);
            default:     w_cmd_ok = !r_rx_shift[DATA_W+1];
        endcase
`endif
    end

    // Receive shifter, word hand-off, read-address tracking and miso serialiser.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_cnt      <= '0;
            r_rx_shift     <= '0;
            r_word_done    <= 1'b0;
            r_rd_addr_seen <= 1'b0;
            r_rd_active    <= 1'b0;
            r_wait_tx      <= 1'b0;
            r_to_cnt       <= '0;
            r_tx_busy      <= 1'b0;
            r_tx_shift     <= '0;
            r_tx_cnt       <= '0;
            r_miso         <= 1'b0;
            r_rx_data      <= '0;
            r_rx_valid     <= 1'b0;
`ifdef SPI_CMD_CHK_EN
            r_cmd_err      <= 1'b0;
`endif
        end else begin
            r_rx_valid <= 1'b0;
`ifdef SPI_CMD_CHK_EN
            r_cmd_err  <= 1'b0;
`endif
            if (w_abort) begin
                // Frame dropped: discard any partial word and stop serial-out.
                r_bit_cnt   <= '0;
                r_rx_shift  <= '0;
                r_word_done <= 1'b0;
                r_rd_active <= 1'b0;
                r_wait_tx   <= 1'b0;
                r_to_cnt    <= '0;
                r_tx_busy   <= 1'b0;
                r_tx_shift  <= '0;
                r_tx_cnt    <= '0;
                r_miso      <= 1'b0;
                if (r_rd_active) begin
                    r_rd_addr_seen <= 1'b0;
                end
            end else begin
                if (w_sample) begin
                    r_rx_shift <= {r_rx_shift[DATA_W:0], mosi};
                    r_bit_cnt  <= r_bit_cnt + 1'b1;
                end

                if (w_emit) begin
                    r_word_done <= 1'b1;
                    if (w_cmd_ok) begin
                        r_rx_data  <= r_rx_shift;
                        r_rx_valid <= 1'b1;
                        if (r_state == S_READ_ADD) begin
                            r_rd_addr_seen <= 1'b1;
                        end
                        if (r_state == S_READ_DATA) begin
                            // Only tx_valid arriving after this word is accepted.
                            r_rd_active <= 1'b1;
                            r_wait_tx   <= 1'b1;
                            r_to_cnt    <= '0;
                        end
                    end else begin
`ifdef SPI_CMD_CHK_EN
                        r_cmd_err <= 1'b1;
`endif
                    end
                end

                if (r_wait_tx) begin
                    if (tx_valid) begin
                        r_wait_tx  <= 1'b0;
                        r_tx_busy  <= 1'b1;
                        r_miso     <= tx_data[DATA_W-1];
                        r_tx_shift <= {tx_data[DATA_W-2:0], 1'b0};
                        r_tx_cnt   <= TX_FIRST;
                    end else if (r_to_cnt == TO_LAST) begin
                        // RAM never answered: give up on this read.
                        r_wait_tx      <= 1'b0;
                        r_rd_addr_seen <= 1'b0;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end

                if (r_tx_busy) begin
                    if (r_tx_cnt != '0) begin
                        r_miso     <= r_tx_shift[DATA_W-1];
                        r_tx_shift <= {r_tx_shift[DATA_W-2:0], 1'b0};
                        r_tx_cnt   <= r_tx_cnt - 1'b1;
                    end else begin
                        r_miso         <= 1'b0;
                        r_tx_busy      <= 1'b0;
                        r_rd_addr_seen <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Directed testbench for spi_slave_ctrl (DATA_W=8, TX_TIMEOUT=15).
module tb_spi_slave_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       ss_n;
    logic       mosi;
    logic       miso;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
`ifdef SPI_CMD_CHK_EN
    logic       cmd_err;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    spi_slave_ctrl #(.DATA_W(8), .TX_TIMEOUT(15)) dut (
        .clk      (clk),
        .rst      (rst),
        .ss_n     (ss_n),
        .mosi     (mosi),
        .miso     (miso),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
`ifdef SPI_CMD_CHK_EN
        ,
        .cmd_err  (cmd_err)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        ss_n = 1'b0;
        mosi = 1'b0;
        tick();
    endtask

    task automatic shift_bits(input logic [9:0] w, input int n);
        for (int i = 9; i > 9 - n; i--) begin
            mosi = w[i];
            tick();
        end
        mosi = 1'b0;
    endtask

    task automatic end_frame();
        ss_n     = 1'b1;
        mosi     = 1'b0;
        tx_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic send_word(input string tag, input logic [9:0] w);
        start_frame();
        shift_bits(w, 10);
        chk({tag, "_early"}, 32'(rx_valid), 32'd0);
        tick();
        chk({tag, "_valid"}, 32'(rx_valid), 32'd1);
        chk({tag, "_data"}, 32'(rx_data), 32'(w));
    endtask

    // Caller drives tx_valid=1 for the load edge.
    task automatic expect_byte(input string tag, input logic [7:0] b);
        tick();
        tx_valid = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            chk(tag, 32'(miso), 32'(b[i]));
            tick();
        end
        chk({tag, "_idle"}, 32'(miso), 32'd0);
    endtask

    task automatic expect_quiet(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk(tag, 32'(miso), 32'd0);
        end
    endtask

    initial begin
        rst      = 1'b1;
        ss_n     = 1'b1;
        mosi     = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        #1;
        chk("rst_miso", 32'(miso), 32'd0);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_rx_data", 32'(rx_data), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Write word, then trailing bits in the same frame are ignored.
        send_word("wr", 10'h0A5);
        tick();
        chk("wr_pulse_end", 32'(rx_valid), 32'd0);
        chk("wr_miso", 32'(miso), 32'd0);
        for (int i = 0; i < 4; i++) begin
            mosi = 1'b1;
            tick();
            chk("wr_extra", 32'(rx_valid), 32'd0);
        end
        end_frame();

        // Abort after 6 bits, then a full frame.
        start_frame();
        shift_bits(10'h0F0, 6);
        ss_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort_no_valid", 32'(rx_valid), 32'd0);
        end
        send_word("abort_next", 10'h1FF);
        end_frame();

        // Read address, then read data with an early (ignored) tx_valid.
        send_word("rd_addr", 10'h203);
        end_frame();
        start_frame();
        tx_data = 8'h5A;
        for (int i = 9; i >= 0; i--) begin
            mosi     = 10'h300 >> i;
            tx_valid = (i == 6) || (i == 5);
            tick();
        end
        tx_valid = 1'b0;
        mosi     = 1'b0;
        chk("rd_early_miso", 32'(miso), 32'd0);
        chk("rd_data_early", 32'(rx_valid), 32'd0);
        tick();
        chk("rd_data_valid", 32'(rx_valid), 32'd1);
        chk("rd_data_word", 32'(rx_data), 32'h300);
        tx_valid = 1'b1;
        tx_data  = 8'hC3;
        expect_byte("rd_miso", 8'hC3);
        end_frame();

        // rd_addr_seen cleared: a 1-leading frame is a read address again.
        send_word("rd_add2", 10'h2A5);
        tx_valid = 1'b1;
        tx_data  = 8'hC3;
        expect_quiet("rd_add2_miso", 10);
        end_frame();

        // Timeout: no tx_valid for 15 cycles, late tx_valid ignored.
        send_word("to", 10'h300);
        expect_quiet("to_wait_miso", 15);
        tx_valid = 1'b1;
        tx_data  = 8'hC3;
        expect_quiet("to_late_miso", 4);
        end_frame();
        send_word("to_next", 10'h2A5);
        tx_valid = 1'b1;
        expect_quiet("to_next_miso", 10);
        end_frame();

        // tx_valid on the last cycle of the window is still accepted.
        send_word("to_edge", 10'h300);
        expect_quiet("to_edge_wait", 14);
        tx_valid = 1'b1;
        tx_data  = 8'h81;
        expect_byte("to_edge_miso", 8'h81);
        end_frame();

        // Reset mid serial-out.
        send_word("rst_add", 10'h203);
        end_frame();
        send_word("rst_rd", 10'h3C0);
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        tick();
        tx_valid = 1'b0;
        chk("rst_pre_miso0", 32'(miso), 32'd1);
        tick();
        chk("rst_pre_miso1", 32'(miso), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_mid_miso", 32'(miso), 32'd0);
        chk("rst_mid_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_mid_rx_data", 32'(rx_data), 32'd0);
        ss_n = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

`ifdef SPI_CMD_CHK_EN
        // 11 command on the read-address path is rejected.
        start_frame();
        shift_bits(10'h3A5, 10);
        tick();
        chk("cmd_err_pulse", 32'(cmd_err), 32'd1);
        chk("cmd_err_no_valid", 32'(rx_valid), 32'd0);
        tick();
        chk("cmd_err_end", 32'(cmd_err), 32'd0);
        end_frame();
`endif

        // After reset the next frame starts from IDLE with rd_addr_seen clear.
        send_word("post_rst", 10'h2A5);
        tx_valid = 1'b1;
        tx_data  = 8'hC3;
        expect_quiet("post_rst_miso", 10);
        end_frame();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
